qdiv_sched: RTL and testbench

QDIV_SCHED -- requirements
Module: qdiv_sched

---
 rtl/qdiv_sched.sv | 207 ++++++++++++++++++++
 tb/tb_qdiv_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdiv_sched.sv
// Round-robin front end that shares one sign-magnitude fixed-point divider
// among four requesters, with divide-by-zero bypass and divider timeouts.
module qdiv_sched #(
    parameter int N    = 32,
    parameter int Q    = 15,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*N-1:0] req_divisor,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_id,
    output logic [N-1:0]      rsp_quotient,
    output logic              rsp_dz,
    output logic              rsp_err,
    output logic              div_start,
    output logic [N-1:0]      div_dividend,
    output logic [N-1:0]      div_divisor,
    input  logic [N-1:0]      div_quotient,
    input  logic              div_complete,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Long timeout is never allowed to be shorter than a complete divide.
    localparam int          TMO_LONG     = (N + Q + 2 > 64) ? (N + Q + 2) : 64;
    localparam logic [6:0]  TMO_LONG_M1  = 7'(TMO_LONG - 1);
    localparam logic [6:0]  TMO_SHORT_M1 = 7'd1;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_last;
    logic [6:0]      r_tmo;
    logic [N-1:0]    r_dividend;
    logic [N-1:0]    r_divisor;
    logic [1:0]      r_rsp_id;
    logic [N-1:0]    r_rsp_quotient;
    logic            r_rsp_dz;
    logic            r_rsp_err;

    logic [2:0]      w_pick;
    logic [1:0]      w_gidx;
    logic            w_hs;
    logic [N-1:0]    w_sel_dvd;
    logic [N-1:0]    w_sel_dvs;
    logic            w_dz;
    logic            w_div_start;
    logic            w_tmo_err;
    logic [NREQ-1:0] w_grant;

    // Returns {found, index}; the search begins just after the last winner.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] valid, input logic [1:0] last);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last + 2'(k);
            if (!res[2] && valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_pick    = rr_pick(req_valid, r_last);
    assign w_gidx    = w_pick[1:0];
    assign w_hs      = (r_state == IDLE) && !rst && w_pick[2];
    assign w_sel_dvd = req_dividend[w_gidx*N +: N];
    assign w_sel_dvs = req_divisor[w_gidx*N +: N];
    assign w_dz      = (w_sel_dvs[N-2:0] == '0);

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        w_grant = '0;
        if (w_hs) begin
            w_grant[w_gidx] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    // Next-state and divider handshake decode.
    always_comb begin
        w_next      = r_state;
        w_div_start = 1'b0;
        w_tmo_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_next = w_dz ? RESP : ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            ISSUE: begin
                if (div_complete) begin
                    w_div_start = 1'b1;
                    w_next      = WAIT_LOW;
                end else if (r_tmo == TMO_LONG_M1) begin
                    w_next    = RESP;
                    w_tmo_err = 1'b1;
                end else begin
                    w_next = ISSUE;
                end
            end
            WAIT_LOW: begin
                if (!div_complete) begin
                    w_next = WAIT_HIGH;
                end else if (r_tmo == TMO_SHORT_M1) begin
                    w_next    = RESP;
                    w_tmo_err = 1'b1;
                end else begin
                    w_next = WAIT_LOW;
                end
            end
            WAIT_HIGH: begin
                if (div_complete) begin
                    w_next = RESP;
                end else if (r_tmo == TMO_LONG_M1) begin
                    w_next    = RESP;
                    w_tmo_err = 1'b1;
                end else begin
                    w_next = WAIT_HIGH;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = RESP;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register and per-state timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_tmo   <= 7'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_tmo <= 7'd0;
            end else if (r_tmo != 7'h7F) begin
                r_tmo <= r_tmo + 7'd1;
            end
        end
    end

    // Captured job operands and the response held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last         <= 2'(NREQ - 1);
            r_dividend     <= '0;
            r_divisor      <= '0;
            r_rsp_id       <= 2'd0;
            r_rsp_quotient <= '0;
            r_rsp_dz       <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else if (w_hs) begin
            r_last     <= w_gidx;
            r_dividend <= w_sel_dvd;
            r_divisor  <= w_sel_dvs;
            r_rsp_id   <= w_gidx;
            if (w_dz) begin
                r_rsp_quotient <= {w_sel_dvd[N-1] ^ w_sel_dvs[N-1], {(N-1){1'b1}}};
                r_rsp_dz       <= 1'b1;
                r_rsp_err      <= 1'b0;
            end
        end else if (r_state == WAIT_HIGH && div_complete) begin
            r_rsp_quotient <= div_quotient;
            r_rsp_dz       <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else if (w_tmo_err) begin
            r_rsp_quotient <= '0;
            r_rsp_dz       <= 1'b0;
            r_rsp_err      <= 1'b1;
        end
    end

    assign req_ready    = w_grant;
    assign div_start    = w_div_start;
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;
    assign rsp_valid    = (r_state == RESP);
    assign rsp_id       = r_rsp_id;
    assign rsp_quotient = r_rsp_quotient;
    assign rsp_dz       = r_rsp_dz;
    assign rsp_err      = r_rsp_err;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_qdiv_sched.sv
// Directed bench for qdiv_sched: behavioural divider model plus a response
// scoreboard filled at each grant handshake and drained as results appear.
module tb_qdiv_sched;

    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int NREQ = 4;
    localparam int LAT  = 45;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] q;
        logic        dz;
        logic        err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_dividend;
    logic [NREQ*N-1:0] req_divisor;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_quotient;
    logic              rsp_dz;
    logic              rsp_err;
    logic              div_start;
    logic [N-1:0]      div_dividend;
    logic [N-1:0]      div_divisor;
    logic [N-1:0]      div_quotient;
    logic              div_complete;
    logic              busy;

    rsp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_start  = 0;
    int          rr_order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] rr_q [4];

    logic        m_cmp = 1'b1;
    int          m_cnt = 0;
    logic [31:0] m_a   = '0;
    logic [31:0] m_b   = '0;
    logic [31:0] m_q   = '0;
    logic        stuck = 1'b0;

    qdiv_sched #(.N(N), .Q(Q), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_dz(rsp_dz), .rsp_err(rsp_err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_complete(div_complete), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fx_div(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] num;
        logic [63:0] quo;
        num = {33'd0, a[30:0]} << Q;
        quo = num / {33'd0, b[30:0]};
        return {a[31] ^ b[31], quo[30:0]};
    endfunction

    function automatic rsp_t mk(input logic [1:0] id, input logic [31:0] q, input logic dz, input logic err);
        rsp_t r;
        r.id  = id;
        r.q   = q;
        r.dz  = dz;
        r.err = err;
        return r;
    endfunction

    // Divider model: no reset, complete drops on start and returns LAT edges later.
    assign div_complete = m_cmp & ~stuck;
    assign div_quotient = m_q;
    always @(posedge clk) begin
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_cmp <= 1'b1;
                m_q   <= fx_div(m_a, m_b);
            end
        end else if (div_start && div_complete) begin
            m_cmp <= 1'b0;
            m_cnt <= LAT;
            m_a   <= div_dividend;
            m_b   <= div_divisor;
        end
    end

    always @(posedge clk) begin
        if (div_start) n_start <= n_start + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag);
        rsp_t e;
        chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp"}, 64'({rsp_valid, rsp_id, rsp_quotient, rsp_dz, rsp_err}), 64'({1'b1, e}));
        end
    endtask

    // Latency k counts edges from the handshake edge to the first edge sampling rsp_valid high.
    task automatic run_job(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input rsp_t e, input int exp_lat, input string tag);
        int k;
        int s0;
        bit hs;
        @(negedge clk);
        req_dividend[idx*N +: N] = a;
        req_divisor[idx*N +: N]  = b;
        req_valid[idx]           = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (req_ready[idx]) begin
                hs = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_grant"}, 64'(hs), 64'd1);
        if (!hs) begin
            req_valid[idx] = 1'b0;
            return;
        end
        sb.push_back(e);
        s0 = n_start;
        @(posedge clk);
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            req_valid[idx] = 1'b0;
            if (rsp_valid) break;
        end
        chk({tag, "_rspv"}, 64'(rsp_valid), 64'd1);
        if (exp_lat > 0) chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
        chk_rsp(tag);
        if (e.dz) chk({tag, "_nostart"}, 64'(n_start - s0), 64'd0);
        if (rsp_ready) begin
            @(negedge clk);
            chk({tag, "_done"}, 64'({rsp_valid, busy}), 64'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t e_st;
        int   g;
        int   last_t;

        rst          = 1'b1;
        rsp_ready    = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("reset", 64'({req_ready, rsp_valid, div_start, rsp_quotient, rsp_id, rsp_dz, rsp_err, busy}), 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // All four contend with zero divisors: order 0,1,2,3,0, a grant every second cycle.
        @(negedge clk);
        req_dividend = {32'h80010000, 32'h00010000, 32'h80008000, 32'h00008000};
        req_divisor  = {32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000};
        rr_q[0] = 32'h7FFFFFFF;
        rr_q[1] = 32'h7FFFFFFF;
        rr_q[2] = 32'hFFFFFFFF;
        rr_q[3] = 32'hFFFFFFFF;
        req_valid = 4'hF;
        g      = 0;
        last_t = 0;
        for (int t = 0; t < 40 && (g < 5 || sb.size() != 0); t++) begin
            #1;
            if (rsp_valid) begin
                chk_rsp("rr");
            end else if (req_ready != 4'b0000) begin
                chk("rr_onehot", 64'($countones(req_ready)), 64'd1);
                chk("rr_order", 64'(req_ready), 64'(4'b0001 << rr_order[g]));
                if (g > 0) chk("rr_gap", 64'(t - last_t), 64'd2);
                sb.push_back(mk(2'(rr_order[g]), rr_q[rr_order[g]], 1'b1, 1'b0));
                last_t = t;
                g++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("rr_count", 64'(g), 64'd5);

        run_job(0, 32'h00018000, 32'h00010000, mk(2'd0, 32'h0000C000, 1'b0, 1'b0), 48, "req020");
        run_job(2, 32'h80018000, 32'h00010000, mk(2'd2, 32'h8000C000, 1'b0, 1'b0), 48, "req021");
        run_job(1, 32'h00008000, 32'h80000000, mk(2'd1, 32'hFFFFFFFF, 1'b1, 1'b0), 1, "req022");

        // Consumer stalls for 20 cycles while requesters 0 and 2 wait.
        rsp_ready = 1'b0;
        e_st = mk(2'd1, fx_div(32'h00030000, 32'h00010000), 1'b0, 1'b0);
        run_job(1, 32'h00030000, 32'h00010000, e_st, 48, "stall");
        req_dividend[0*N +: N] = 32'h00010000;
        req_divisor[0*N +: N]  = 32'h00000000;
        req_dividend[2*N +: N] = 32'h00010000;
        req_divisor[2*N +: N]  = 32'h00000000;
        req_valid = 4'b0101;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            chk("stall_hold", 64'({rsp_valid, rsp_id, rsp_quotient, rsp_dz, rsp_err, req_ready}),
                64'({1'b1, e_st, 4'b0000}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_accept", 64'({rsp_valid, busy}), 64'd0);
        chk("stall_next_rr", 64'(req_ready), 64'(4'b0100));
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("drop_ignored", 64'({busy, req_ready}), 64'd0);

        stuck = 1'b1;
        run_job(3, 32'h00010000, 32'h00010000, mk(2'd3, 32'h00000000, 1'b0, 1'b1), 65, "tmo");
        stuck = 1'b0;

        // Reset in WAIT_HIGH abandons the job; the divider keeps running underneath.
        @(negedge clk);
        req_dividend[0*N +: N] = 32'h00050000;
        req_divisor[0*N +: N]  = 32'h00010000;
        req_valid = 4'b0001;
        #1;
        chk("rst_job_grant", 64'(req_ready), 64'(4'b0001));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (9) @(negedge clk);
        chk("rst_pre", 64'({busy, rsp_valid}), 64'(2'b10));
        req_dividend[1*N +: N] = 32'h00010000;
        req_divisor[1*N +: N]  = 32'h00010000;
        rst       = 1'b1;
        req_valid = 4'b0011;
        #1;
        chk("rst_mid", 64'({req_ready, rsp_valid, div_start, rsp_quotient, rsp_id, rsp_dz, rsp_err, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rr", 64'(req_ready), 64'(4'b0001));
        req_valid = '0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("rst_quiet", 64'({rsp_valid, busy}), 64'd0);
        end
        run_job(0, 32'h00010000, 32'h00040000, mk(2'd0, 32'h00002000, 1'b0, 1'b0), -1, "post_rst");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
